// File: rtl/vcache_stat_collector_if.sv
// Record output channel of the vcache statistics collector: one valid/ready
// handshake carrying a per-channel snapshot record.
interface vcache_stat_collector_if #(
  parameter int lg_num_p     = 2,
  parameter int data_width_p = 32,
  parameter int ctr_width_p  = 32
);
  logic                    stat_v_o;
  logic                    stat_ready_i;
  logic [lg_num_p-1:0]     stat_cache_id_o;
  logic [data_width_p-1:0] stat_tag_o;
  logic [31:0]             stat_global_ctr_o;
  logic [ctr_width_p-1:0]  stat_ld_o;
  logic [ctr_width_p-1:0]  stat_st_o;
  logic [ctr_width_p-1:0]  stat_ld_miss_o;
  logic [ctr_width_p-1:0]  stat_st_miss_o;
  logic [ctr_width_p-1:0]  stat_stall_o;

  modport master (
    output stat_v_o, stat_cache_id_o, stat_tag_o, stat_global_ctr_o,
           stat_ld_o, stat_st_o, stat_ld_miss_o, stat_st_miss_o, stat_stall_o,
    input  stat_ready_i
  );

  modport slave (
    input  stat_v_o, stat_cache_id_o, stat_tag_o, stat_global_ctr_o,
           stat_ld_o, stat_st_o, stat_ld_miss_o, stat_st_miss_o, stat_stall_o,
    output stat_ready_i
  );
endinterface

// File: rtl/vcache_stat_collector.sv
// Per-channel saturating vcache event counters with a snapshot that is drained
// one record per channel over a valid/ready interface.
module vcache_stat_collector #(
  parameter int num_caches_p        = 4,
  parameter int ctr_width_p         = 32,
  parameter int data_width_p        = 32,
  parameter bit clear_on_snapshot_p = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [num_caches_p-1:0] v_o_i,
  input  logic [num_caches_p-1:0] yumi_i,
  input  logic [num_caches_p-1:0] v_v_r_i,
  input  logic [num_caches_p-1:0] miss_v_i,
  input  logic [num_caches_p-1:0] ld_op_i,
  input  logic [num_caches_p-1:0] st_op_i,
  input  logic [31:0]             global_ctr_i,
  input  logic                    print_stat_v_i,
  input  logic [data_width_p-1:0] print_stat_tag_i,
  vcache_stat_collector_if.master stat_if,
  output logic                    busy_o,
  output logic                    dropped_o
);
  localparam int lg_num_lp = (num_caches_p > 1) ? $clog2(num_caches_p) : 1;
  localparam int EV_LD     = 0;
  localparam int EV_ST     = 1;
  localparam int EV_LDM    = 2;
  localparam int EV_STM    = 3;
  localparam int EV_STALL  = 4;

  typedef enum logic {IDLE, DRAIN} state_e;
  state_e state_q, state_d;

  logic [num_caches_p-1:0][4:0]                  ev;
  logic [num_caches_p-1:0][4:0][ctr_width_p-1:0] live_q, live_d, snap_q;
  logic [4:0][ctr_width_p-1:0]                   rec;
  logic [ctr_width_p-1:0]                        base;
  logic [data_width_p-1:0]                       tag_q;
  logic [31:0]                                   gctr_q;
  logic [lg_num_lp-1:0]                          idx_q;
  logic                                          dropped_q;
  logic                                          take, last, hs;

  assign take = (state_q == IDLE) && print_stat_v_i;
  assign last = (idx_q == lg_num_lp'(num_caches_p - 1));
  assign hs   = stat_if.stat_v_o && stat_if.stat_ready_i;

  always_comb begin
    ev = '0;
    for (int unsigned i = 0; i < num_caches_p; i++) begin
      ev[i][EV_LD]    = v_o_i[i] & yumi_i[i] & ld_op_i[i];
      ev[i][EV_ST]    = v_o_i[i] & yumi_i[i] & st_op_i[i];
      ev[i][EV_LDM]   = v_o_i[i] & yumi_i[i] & ld_op_i[i] & miss_v_i[i];
      ev[i][EV_STM]   = v_o_i[i] & yumi_i[i] & st_op_i[i] & miss_v_i[i];
      ev[i][EV_STALL] = v_v_r_i[i] & miss_v_i[i] & ~(v_o_i[i] | yumi_i[i]);
    end
  end

  // The snapshot samples live_q, so this cycle's event lands only in the live
  // counter, on top of zero when clearing on snapshot.
  always_comb begin
    live_d = live_q;
    base   = '0;
    for (int unsigned i = 0; i < num_caches_p; i++) begin
      for (int unsigned e = 0; e < 5; e++) begin
        base = (take && clear_on_snapshot_p) ? '0 : live_q[i][e];
        if (ev[i][e] && (base != '1)) live_d[i][e] = base + ctr_width_p'(1);
        else                          live_d[i][e] = base;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (take)      state_d = DRAIN;
      DRAIN:   if (hs && last) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    stat_if.stat_v_o = (state_q == DRAIN);
    busy_o           = (state_q == DRAIN);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      live_q    <= '0;
      snap_q    <= '0;
      tag_q     <= '0;
      gctr_q    <= '0;
      idx_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      live_q <= live_d;
      if (take) begin
        snap_q <= live_q;
        tag_q  <= print_stat_tag_i;
        gctr_q <= global_ctr_i;
        idx_q  <= '0;
      end else if (hs && !last) begin
        idx_q <= idx_q + lg_num_lp'(1);
      end
      if (print_stat_v_i && (state_q == DRAIN)) dropped_q <= 1'b1;
    end
  end

  always_comb begin
    rec = '0;
    for (int unsigned i = 0; i < num_caches_p; i++) begin
      if (idx_q == lg_num_lp'(i)) rec = snap_q[i];
    end
  end

  assign stat_if.stat_cache_id_o   = idx_q;
  assign stat_if.stat_tag_o        = tag_q;
  assign stat_if.stat_global_ctr_o = gctr_q;
  assign stat_if.stat_ld_o         = rec[EV_LD];
  assign stat_if.stat_st_o         = rec[EV_ST];
  assign stat_if.stat_ld_miss_o    = rec[EV_LDM];
  assign stat_if.stat_st_miss_o    = rec[EV_STM];
  assign stat_if.stat_stall_o      = rec[EV_STALL];
  assign dropped_o                 = dropped_q;
endmodule

// File: tb/tb_vcache_stat_collector.sv
// Drives two collectors (32-bit counters without clear, 4-bit counters with
// clear-on-snapshot) with shared stimulus and scoreboards their records.
module tb_vcache_stat_collector;
  localparam int N  = 4;
  localparam int LG = 2;

  typedef struct {
    logic [63:0] id, tag, g, ld, st, ldm, stm, stl;
  } rec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0] vo, yumi, vvr, miss, ld, st;
  logic [31:0]  gctr, tag;
  logic         prn, rdy;
  logic         busy_a, drop_a, busy_b, drop_b;

  vcache_stat_collector_if #(.lg_num_p(LG), .data_width_p(32), .ctr_width_p(32)) ifa ();
  vcache_stat_collector_if #(.lg_num_p(LG), .data_width_p(32), .ctr_width_p(4))  ifb ();
  assign ifa.stat_ready_i = rdy;
  assign ifb.stat_ready_i = rdy;

  vcache_stat_collector #(.num_caches_p(N), .ctr_width_p(32), .data_width_p(32),
                          .clear_on_snapshot_p(1'b0)) dut_a (
    .clk_i(clk), .reset_i(rst), .v_o_i(vo), .yumi_i(yumi), .v_v_r_i(vvr),
    .miss_v_i(miss), .ld_op_i(ld), .st_op_i(st), .global_ctr_i(gctr),
    .print_stat_v_i(prn), .print_stat_tag_i(tag), .stat_if(ifa),
    .busy_o(busy_a), .dropped_o(drop_a));

  vcache_stat_collector #(.num_caches_p(N), .ctr_width_p(4), .data_width_p(32),
                          .clear_on_snapshot_p(1'b1)) dut_b (
    .clk_i(clk), .reset_i(rst), .v_o_i(vo), .yumi_i(yumi), .v_v_r_i(vvr),
    .miss_v_i(miss), .ld_op_i(ld), .st_op_i(st), .global_ctr_i(gctr),
    .print_stat_v_i(prn), .print_stat_tag_i(tag), .stat_if(ifb),
    .busy_o(busy_b), .dropped_o(drop_b));

  int passes = 0;
  int total  = 0;

  // Reference model: plain event counts per (dut, cache, kind), a count of
  // records still owed, and a sticky drop flag.
  logic [63:0] cnt [2][N][5];
  int          pend;
  bit          dropped;
  rec_t        q0[$];
  rec_t        q1[$];

  function automatic logic [63:0] maxv(input int d);
    return (d == 0) ? 64'hFFFF_FFFF : 64'd15;
  endfunction

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic cmp_rec(input string nm, input rec_t a, input rec_t e);
    cmp({nm, "_id"},      a.id,  e.id);
    cmp({nm, "_tag"},     a.tag, e.tag);
    cmp({nm, "_gctr"},    a.g,   e.g);
    cmp({nm, "_ld"},      a.ld,  e.ld);
    cmp({nm, "_st"},      a.st,  e.st);
    cmp({nm, "_ld_miss"}, a.ldm, e.ldm);
    cmp({nm, "_st_miss"}, a.stm, e.stm);
    cmp({nm, "_stall"},   a.stl, e.stl);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++)
        for (int e = 0; e < 5; e++) cnt[d][c][e] = 64'd0;
    pend    = 0;
    dropped = 1'b0;
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    bit   ev [N][5];
    bit   take, a;
    rec_t r;
    logic [63:0] b;
    if (rst) begin
      model_reset();
      return;
    end
    for (int c = 0; c < N; c++) begin
      a        = vo[c] & yumi[c];
      ev[c][0] = a & ld[c];
      ev[c][1] = a & st[c];
      ev[c][2] = a & ld[c] & miss[c];
      ev[c][3] = a & st[c] & miss[c];
      ev[c][4] = vvr[c] & miss[c] & !(vo[c] | yumi[c]);
    end
    take = 1'b0;
    if (pend == 0) take = prn;
    else begin
      if (prn) dropped = 1'b1;
      if (rdy) pend--;
    end
    if (take) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < N; c++) begin
          r.id = 64'(c); r.tag = 64'(tag); r.g = 64'(gctr);
          r.ld = cnt[d][c][0]; r.st = cnt[d][c][1]; r.ldm = cnt[d][c][2];
          r.stm = cnt[d][c][3]; r.stl = cnt[d][c][4];
          if (d == 0) q0.push_back(r);
          else        q1.push_back(r);
        end
      pend = N;
    end
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++)
        for (int e = 0; e < 5; e++) begin
          b = (take && d == 1) ? 64'd0 : cnt[d][c][e];
          if (ev[c][e] && b < maxv(d)) b = b + 64'd1;
          cnt[d][c][e] = b;
        end
  endtask

  task automatic clear_inputs();
    vo = '0; yumi = '0; vvr = '0; miss = '0; ld = '0; st = '0; prn = 1'b0;
  endtask

  // One cycle: check control outputs mid-cycle, then advance model and inputs.
  task automatic tick();
    bit ev_v;
    @(negedge clk);
    ev_v = !rst && (pend > 0);
    cmp("A_stat_v",  64'(ifa.stat_v_o), 64'(ev_v));
    cmp("B_stat_v",  64'(ifb.stat_v_o), 64'(ev_v));
    cmp("A_busy",    64'(busy_a),       64'(ev_v));
    cmp("B_busy",    64'(busy_b),       64'(ev_v));
    cmp("A_dropped", 64'(drop_a),       64'(dropped));
    cmp("B_dropped", 64'(drop_b),       64'(dropped));
    @(posedge clk);
    model_step();
    #1;
    clear_inputs();
    gctr = gctr + 32'd1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && pend > 0; i++) tick();
    tick();
  endtask

  task automatic hit(input int c, input bit is_ld, input bit is_miss);
    vo[c] = 1'b1; yumi[c] = 1'b1; miss[c] = is_miss;
    if (is_ld) ld[c] = 1'b1;
    else       st[c] = 1'b1;
  endtask

  always @(negedge clk) begin : mon_a
    rec_t r;
    if (!rst && ifa.stat_v_o) begin
      r.id = 64'(ifa.stat_cache_id_o); r.tag = 64'(ifa.stat_tag_o);
      r.g = 64'(ifa.stat_global_ctr_o); r.ld = 64'(ifa.stat_ld_o);
      r.st = 64'(ifa.stat_st_o); r.ldm = 64'(ifa.stat_ld_miss_o);
      r.stm = 64'(ifa.stat_st_miss_o); r.stl = 64'(ifa.stat_stall_o);
      if (q0.size() == 0) cmp("A_unexpected_record", 64'd1, 64'd0);
      else begin
        cmp_rec("A", r, q0[0]);
        if (rdy) void'(q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_b
    rec_t r;
    if (!rst && ifb.stat_v_o) begin
      r.id = 64'(ifb.stat_cache_id_o); r.tag = 64'(ifb.stat_tag_o);
      r.g = 64'(ifb.stat_global_ctr_o); r.ld = 64'(ifb.stat_ld_o);
      r.st = 64'(ifb.stat_st_o); r.ldm = 64'(ifb.stat_ld_miss_o);
      r.stm = 64'(ifb.stat_st_miss_o); r.stl = 64'(ifb.stat_stall_o);
      if (q1.size() == 0) cmp("B_unexpected_record", 64'd1, 64'd0);
      else begin
        cmp_rec("B", r, q1[0]);
        if (rdy) void'(q1.pop_front());
      end
    end
  end

  initial begin
    clear_inputs();
    gctr = 32'h1000_0000;
    tag  = '0;
    rdy  = 1'b1;
    rst  = 1'b1;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Cache 2: 5 stalls, 1 ld miss, 3 ld hits, 2 st, then snapshot tag 0xAB.
    repeat (5) begin vvr[2] = 1'b1; miss[2] = 1'b1; tick(); end
    hit(2, 1'b1, 1'b1); tick();
    repeat (3) begin hit(2, 1'b1, 1'b0); tick(); end
    repeat (2) begin hit(2, 1'b0, 1'b0); tick(); end
    tag = 32'hAB; prn = 1'b1; tick();
    drain();

    // 20 ld hits on cache 0: the 4-bit collector saturates at 15.
    repeat (20) begin hit(0, 1'b1, 1'b0); tick(); end
    tag = 32'h5A; prn = 1'b1; tick();
    drain();

    // Back-pressure for 10 cycles with a second request in the middle.
    rdy = 1'b0;
    tag = 32'h77; prn = 1'b1; tick();
    repeat (4) begin hit(3, 1'b0, 1'b1); tick(); end
    tag = 32'h99; prn = 1'b1; tick();
    repeat (5) tick();
    rdy = 1'b1;
    drain();

    // Event in the snapshot cycle, then a later snapshot.
    hit(1, 1'b1, 1'b0); tag = 32'h11; prn = 1'b1; tick();
    drain();
    tag = 32'h22; prn = 1'b1; tick();
    drain();

    // Reset while record 1 is pending, then snapshot an all-zero state.
    hit(0, 1'b1, 1'b0); tick();
    tag = 32'h33; prn = 1'b1; tick();
    tick();
    rdy = 1'b0; tick();
    rst = 1'b1; model_reset(); tick(); tick();
    rst = 1'b0; rdy = 1'b1; tick();
    tag = 32'h44; prn = 1'b1; tick();
    drain();

    repeat (1500) begin
      vo = 4'($urandom); yumi = 4'($urandom); vvr = 4'($urandom);
      miss = 4'($urandom); ld = 4'($urandom); st = 4'($urandom);
      prn = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      tag = $urandom;
      tick();
    end
    rdy = 1'b1;
    drain();
    cmp("A_records_left", 64'(q0.size()), 64'd0);
    cmp("B_records_left", 64'(q1.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/vcache_stat_collector.md
VCACHE_STAT_COLLECTOR -- requirements
Module: vcache_stat_collector

Interface
REQ-001 Parameter num_caches_p, default 4: number of vcache channels monitored; SHALL be at least 1.
REQ-002 Parameter ctr_width_p, default 32: width of every event counter.
REQ-003 Parameter data_width_p, default 32: width of the stat tag.
REQ-004 Parameter clear_on_snapshot_p, default 0: when 1, counters clear when a snapshot is taken.
REQ-005 Local lg_num_lp = max(1, clog2(num_caches_p)).
REQ-006 clk_i  in  1  sole clock; all state updates on posedge.
REQ-007 reset_i  in  1  asynchronous, active-high reset.
REQ-008 v_o_i, yumi_i, v_v_r_i, miss_v_i, ld_op_i, st_op_i  in  num_caches_p each  per-channel verify-stage signals; bit i belongs to cache i.
REQ-009 global_ctr_i  in  32  free-running global cycle counter.
REQ-010 print_stat_v_i  in  1  snapshot request, one cycle.
REQ-011 print_stat_tag_i  in  data_width_p  tag attached to the snapshot.
REQ-012 stat_v_o  out  1 / stat_ready_i  in  1  valid/ready handshake for the record output.
REQ-013 stat_cache_id_o  out  lg_num_lp  channel index of the current record.
REQ-014 stat_tag_o  out  data_width_p / stat_global_ctr_o  out  32  snapshot tag and global counter.
REQ-015 stat_ld_o, stat_st_o, stat_ld_miss_o, stat_st_miss_o, stat_stall_o  out  ctr_width_p each  snapshot counts.
REQ-016 busy_o  out  1  high while in DRAIN.
REQ-017 dropped_o  out  1  sticky: a snapshot request was lost.

Function
REQ-018 Per channel i, each cycle: inc_ld = v_o&yumi&ld_op; inc_st = v_o&yumi&st_op; inc_ld_miss = inc_ld&miss_v; inc_st_miss = inc_st&miss_v; stall = v_v_r&miss_v&~(v_o|yumi).
REQ-019 Each of the 5 counters per channel SHALL increment by 1 on its event and saturate at 2^ctr_width_p-1; it never wraps.
REQ-020 FSM states: IDLE and DRAIN; reset state IDLE.
REQ-021 In IDLE, print_stat_v_i=1 SHALL copy all 5*num_caches_p counters, print_stat_tag_i and global_ctr_i into snapshot registers, set the record index to 0, and enter DRAIN the next cycle.
REQ-022 The snapshot SHALL hold pre-increment values: an event in the snapshot cycle is not in the snapshot but is kept in the live counter.
REQ-023 With clear_on_snapshot_p=1, each live counter SHALL become 0 plus that cycle's event (0 or 1) in the snapshot cycle; with 0, counting continues unchanged.
REQ-024 In DRAIN, stat_v_o=1 SHALL present the record for snapshot index k, with stat_cache_id_o=k and the shared tag and global_ctr.
REQ-025 Record k SHALL stay stable while stat_v_o=1 and stat_ready_i=0.
REQ-026 On stat_v_o&stat_ready_i: if k<num_caches_p-1, k SHALL increment; else the FSM SHALL return to IDLE and stat_v_o SHALL be 0 the next cycle.
REQ-027 A record transfer takes one cycle minimum; a full drain takes at least num_caches_p cycles.
REQ-028 print_stat_v_i in DRAIN, including the final handshake cycle, SHALL be ignored and SHALL set dropped_o; the snapshot SHALL not change.
REQ-029 dropped_o SHALL clear only on reset.
REQ-030 Live counters SHALL keep counting during DRAIN.
REQ-031 stat_v_o SHALL be 0 in IDLE; record outputs SHALL not be checked in IDLE.

Reset
REQ-032 Asserting reset_i at any time, including mid-DRAIN, SHALL immediately force: FSM to IDLE, stat_v_o=0, busy_o=0, dropped_o=0, all live and snapshot counters to 0, record index to 0.
REQ-033 No event counts and no snapshot request while reset_i=1.

Verification
REQ-034 num_caches_p=4, ctr_width_p=32: cache 2 has 3 ld hits, 1 ld miss preceded by 5 stall cycles, 2 st; then print with tag 0xAB, ready=1 -> 4 records in consecutive cycles; record 2 shows ld=4, st=2, ld_miss=1, st_miss=0, stall=5, tag=0xAB; other records all 0.
REQ-035 ctr_width_p=4: 20 ld hits on cache 0, then print -> stat_ld_o=15 (saturated).
REQ-036 Print with stat_ready_i held 0 for 10 cycles, then 1 -> record 0 stable and stat_v_o=1 all 10 cycles; a second print during the stall sets dropped_o=1 and records are unchanged.
REQ-037 clear_on_snapshot_p=1: ld event on cache 1 in the print cycle -> snapshot ld excludes it, live ld=1 after; a second print later reports ld=1.
REQ-038 Assert reset_i while record 1 is pending -> stat_v_o=0, busy_o=0, dropped_o=0 at once; a later print reports all counters 0.
